// File: rtl/estagio_busca.sv
// Instruction-fetch stage: program counter, instruction-memory addressing and
// the IF/ID pipeline register, with stall, redirect/flush, halt and fetch counting.
module estagio_busca #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          MEM_WORDS_LOG2 = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redir_valid,
    input  logic [31:0] redir_pc,
    input  logic        halt_req,
    output logic [31:0] mi_addr,
    input  logic [31:0] mi_data,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic [31:0] pc,
    output logic        exc_misalign,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic        misalign_q, misalign_d;
    logic [31:0] count_q, count_d;

    logic [31:0] pc_plus4;
    logic [31:0] redir_target;
    logic        take_redirect;

    assign pc_plus4      = pc_q + 32'd4;
    assign redir_target  = {redir_pc[31:2], 2'b00};
    // A redirect wins in both RUN and HALTED; BOOT ignores every request.
    assign take_redirect = redir_valid && (state_q != ST_BOOT);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        pc4_d      = pc4_q;
        valid_d    = valid_q;
        misalign_d = misalign_q;
        count_d    = count_q;

        if (take_redirect) begin
            state_d    = ST_RUN;
            pc_d       = redir_target;
            instr_d    = 32'd0;
            pc4_d      = 32'd0;
            valid_d    = 1'b0;
            misalign_d = misalign_q | (redir_pc[1:0] != 2'b00);
        end else begin
            case (state_q)
                ST_BOOT: begin
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (halt_req) begin
                        state_d = ST_HALTED;
                        instr_d = 32'd0;
                        pc4_d   = 32'd0;
                        valid_d = 1'b0;
                    end else if (!stall) begin
                        instr_d = mi_data;
                        pc4_d   = pc_plus4;
                        valid_d = 1'b1;
                        pc_d    = pc_plus4;
                        count_d = count_q + 32'd1;
                    end
                end
                ST_HALTED: begin
                    state_d = ST_HALTED;
                end
                default: begin
                    state_d = ST_BOOT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            instr_q    <= 32'd0;
            pc4_q      <= 32'd0;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
            count_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pc4_q      <= pc4_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
            count_q    <= count_d;
        end
    end

    // Only the low word-index bits reach memory, so large PCs alias.
    assign mi_addr      = {{(32 - MEM_WORDS_LOG2){1'b0}}, pc_q[MEM_WORDS_LOG2+1:2]};
    assign pc           = pc_q;
    assign if_id_instr  = instr_q;
    assign if_id_pc4    = pc4_q;
    assign if_id_valid  = valid_q;
    assign exc_misalign = misalign_q;
    assign fetch_count  = count_q;

endmodule

// File: tb/tb_estagio_busca.sv
// Directed bench for estagio_busca: behavioural fetch model checked every cycle,
// plus literal expectations that pin the model at key points.
module tb_estagio_busca;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        halt_req;
    logic [31:0] mi_addr;
    logic [31:0] mi_data;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic [31:0] pc;
    logic        exc_misalign;
    logic [31:0] fetch_count;

    logic [31:0] mem [32];

    int n_checks;
    int n_fail;

    // Model: what the fetch stage should present, in plain terms.
    logic [31:0] m_pc, m_instr, m_pc4, m_count;
    logic        m_valid, m_mis, m_booting, m_halted;

    estagio_busca #(.RESET_PC(32'h0), .MEM_WORDS_LOG2(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .redir_valid  (redir_valid),
        .redir_pc     (redir_pc),
        .halt_req     (halt_req),
        .mi_addr      (mi_addr),
        .mi_data      (mi_data),
        .if_id_instr  (if_id_instr),
        .if_id_pc4    (if_id_pc4),
        .if_id_valid  (if_id_valid),
        .pc           (pc),
        .exc_misalign (exc_misalign),
        .fetch_count  (fetch_count)
    );

    assign mi_data = mem[mi_addr[4:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc      = 32'h0;
        m_instr   = 32'h0;
        m_pc4     = 32'h0;
        m_count   = 32'h0;
        m_valid   = 1'b0;
        m_mis     = 1'b0;
        m_booting = 1'b1;
        m_halted  = 1'b0;
    endtask

    task automatic model_step(input logic st, input logic rv, input logic [31:0] rp, input logic hr);
        if (m_booting) begin
            m_booting = 1'b0;
        end else if (rv) begin
            m_pc     = rp - (rp % 4);
            m_instr  = 32'h0;
            m_pc4    = 32'h0;
            m_valid  = 1'b0;
            m_halted = 1'b0;
            if (rp % 4 != 0) m_mis = 1'b1;
        end else if (m_halted) begin
            // frozen until a redirect
        end else if (hr) begin
            m_instr  = 32'h0;
            m_pc4    = 32'h0;
            m_valid  = 1'b0;
            m_halted = 1'b1;
        end else if (!st) begin
            m_instr = mem[(m_pc / 4) % 32];
            m_pc    = m_pc + 4;
            m_pc4   = m_pc;
            m_valid = 1'b1;
            m_count = m_count + 1;
        end
    endtask

    task automatic compare_all();
        check("pc", pc, m_pc);
        check("mi_addr", mi_addr, (m_pc / 4) % 32);
        check("if_id_instr", if_id_instr, m_instr);
        check("if_id_pc4", if_id_pc4, m_pc4);
        check("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
        check("exc_misalign", {31'd0, exc_misalign}, {31'd0, m_mis});
        check("fetch_count", fetch_count, m_count);
    endtask

    // Called at a falling edge: drive inputs, let one rising edge pass, compare.
    task automatic cyc(input logic st, input logic rv, input logic [31:0] rp, input logic hr);
        stall       = st;
        redir_valid = rv;
        redir_pc    = rp;
        halt_req    = hr;
        @(posedge clk);
        model_step(st, rv, rp, hr);
        @(negedge clk);
        compare_all();
        $display("cyc st=%0b rv=%0b rp=%h hr=%0b -> pc=%h instr=%h pc4=%h v=%0b mis=%0b cnt=%0d",
                 st, rv, rp, hr, pc, if_id_instr, if_id_pc4, if_id_valid, exc_misalign, fetch_count);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 32; i++) mem[i] = 32'hA000_0000 + i;
        stall = 1'b0; redir_valid = 1'b0; redir_pc = 32'h0; halt_req = 1'b0;

        // Reset, then free run
        rst_n = 1'b0;
        model_reset();
        #1 compare_all();
        repeat (2) @(negedge clk);
        check("reset pc", pc, 32'h0);
        check("reset valid", {31'd0, if_id_valid}, 32'd0);
        rst_n = 1'b1;
        compare_all();

        cyc(0, 0, 32'h0, 0);
        check("boot pc", pc, 32'h0);
        check("boot valid", {31'd0, if_id_valid}, 32'd0);
        cyc(0, 0, 32'h0, 0);
        check("A0 instr", if_id_instr, 32'hA000_0000);
        check("A0 pc4", if_id_pc4, 32'h4);
        cyc(0, 0, 32'h0, 0);
        check("A1 instr", if_id_instr, 32'hA000_0001);
        check("pc at 8", pc, 32'h8);

        // Stall two cycles at pc=8
        cyc(1, 0, 32'h0, 0);
        cyc(1, 0, 32'h0, 0);
        check("stall pc", pc, 32'h8);
        check("stall instr", if_id_instr, 32'hA000_0001);
        check("stall count", fetch_count, 32'd2);
        cyc(0, 0, 32'h0, 0);
        check("resume instr", if_id_instr, 32'hA000_0002);
        check("resume pc", pc, 32'hC);
        check("count 3", fetch_count, 32'd3);

        // Redirect while stalled
        cyc(1, 1, 32'h10, 0);
        check("redir pc", pc, 32'h10);
        check("redir bubble", {31'd0, if_id_valid}, 32'd0);
        cyc(0, 0, 32'h0, 0);
        check("word4 instr", if_id_instr, 32'hA000_0004);
        check("word4 pc4", if_id_pc4, 32'h14);

        // Misaligned redirect, sticky flag
        cyc(0, 1, 32'h16, 0);
        check("misalign pc", pc, 32'h14);
        check("misalign set", {31'd0, exc_misalign}, 32'd1);
        cyc(0, 1, 32'h8, 0);
        cyc(0, 0, 32'h0, 0);
        cyc(0, 0, 32'h0, 0);
        check("misalign sticky", {31'd0, exc_misalign}, 32'd1);

        // Halt at pc=12
        cyc(0, 1, 32'hC, 0);
        cyc(0, 0, 32'h0, 1);
        check("halt valid", {31'd0, if_id_valid}, 32'd0);
        for (int i = 0; i < 5; i++) cyc(i[0], 0, 32'h0, ~i[0]);
        check("halt pc frozen", pc, 32'hC);
        cyc(0, 1, 32'h0, 1);
        check("unhalt pc", pc, 32'h0);
        cyc(0, 0, 32'h0, 0);
        check("unhalt A0", if_id_instr, 32'hA000_0000);
        // Halt and redirect together in RUN: redirect wins
        cyc(0, 1, 32'h20, 1);
        cyc(0, 0, 32'h0, 0);
        check("redir over halt", if_id_instr, 32'hA000_0008);
        check("redir over halt v", {31'd0, if_id_valid}, 32'd1);

        // PC wrap and memory aliasing
        cyc(0, 1, 32'hFFFF_FFFC, 0);
        check("alias addr", mi_addr, 32'd31);
        cyc(0, 0, 32'h0, 0);
        check("wrap pc", pc, 32'h0);
        check("wrap instr", if_id_instr, 32'hA000_001F);

        // Reach pc=20 with a valid IF/ID, then reset mid-cycle
        cyc(0, 1, 32'h10, 0);
        cyc(0, 0, 32'h0, 0);
        check("pre-reset pc", pc, 32'h14);
        #2 rst_n = 1'b0;
        model_reset();
        #1 compare_all();
        check("async pc", pc, 32'h0);
        check("async valid", {31'd0, if_id_valid}, 32'd0);
        check("async mis", {31'd0, exc_misalign}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        compare_all();
        cyc(0, 0, 32'h0, 0);
        check("reboot pc", pc, 32'h0);
        cyc(0, 0, 32'h0, 0);
        check("reboot A0", if_id_instr, 32'hA000_0000);
        check("reboot count", fetch_count, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
